// File: rtl/multicast_fanout_pkg.sv
// Shared router constants, direction codes and fanout FSM state encoding.
package multicast_fanout_pkg;

    localparam int unsigned ValidBitPos    = 81;
    localparam int unsigned lg_numprocs    = 3;
    localparam int unsigned FlitWidth      = ValidBitPos + 1;
    localparam int unsigned FlitChildWidth = FlitWidth + lg_numprocs;
    localparam int unsigned ROUTE_LEN      = 3;
    localparam int unsigned PORT_NUM       = 6;

    localparam logic [ROUTE_LEN-1:0] DIR_XPOS = 3'd0;
    localparam logic [ROUTE_LEN-1:0] DIR_XNEG = 3'd1;
    localparam logic [ROUTE_LEN-1:0] DIR_YPOS = 3'd2;
    localparam logic [ROUTE_LEN-1:0] DIR_YNEG = 3'd3;
    localparam logic [ROUTE_LEN-1:0] DIR_ZPOS = 3'd4;
    localparam logic [ROUTE_LEN-1:0] DIR_ZNEG = 3'd5;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/fanout_port_slot.sv
// One output port's pending-copy bit and its valid/avail handshake.
module fanout_port_slot (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic load_bit,
    input  logic out_avail,
    output logic pending,
    output logic blocked
);

    // A new load wins over a same-cycle drain: the old copy is delivered
    // at this edge and the new flit's bit takes its place.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            pending <= 1'b0;
        else if (load)
            pending <= load_bit;
        else if (pending && out_avail)
            pending <= 1'b0;
    end

    assign blocked = pending & ~out_avail;

endmodule

// File: rtl/multicast_fanout.sv
// Replicates one accepted flit to every port in its destination mask.
// Optional perf counters are enabled by defining MCAST_PERF_CNT_EN.
module multicast_fanout
    import multicast_fanout_pkg::*;
#(
    parameter int unsigned FAN_OUT = PORT_NUM
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [FlitChildWidth-1:0]         in,
    input  logic [FAN_OUT-1:0]                in_dst_mask,
    input  logic                              in_valid,
    output logic                              in_avail,
    output logic [FAN_OUT*FlitChildWidth-1:0] out,
    output logic [FAN_OUT-1:0]                out_valid,
    input  logic [FAN_OUT-1:0]                out_avail
`ifdef MCAST_PERF_CNT_EN
    ,
    output logic [31:0]                       flit_cnt,
    output logic [31:0]                       drop_cnt,
    output logic [31:0]                       stall_cnt
`endif
);

    state_t                    state, state_d;
    logic                      alive;
    logic                      accept;
    logic [FlitChildWidth-1:0] held;
    logic [FAN_OUT-1:0]        pending;
    logic [FAN_OUT-1:0]        blocked;

    // Holds in_avail low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            alive <= 1'b0;
        else
            alive <= 1'b1;
    end

    assign in_avail = alive & ((state == IDLE) | ~(|blocked));
    assign accept   = in_valid & in_avail;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            held  <= '0;
        end else begin
            state <= state_d;
            if (accept)
                held <= in;
        end
    end

    always_comb begin
        state_d = state;
        if (accept)
            state_d = (|in_dst_mask) ? SEND : IDLE;
        else if (state == SEND && !(|blocked))
            state_d = IDLE;
    end

    for (genvar i = 0; i < FAN_OUT; i++) begin : g_port
        fanout_port_slot u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (accept),
            .load_bit  (in_dst_mask[i]),
            .out_avail (out_avail[i]),
            .pending   (pending[i]),
            .blocked   (blocked[i])
        );
        assign out[i*FlitChildWidth +: FlitChildWidth] = held;
    end

    assign out_valid = pending;

`ifdef MCAST_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flit_cnt  <= '0;
            drop_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (accept)
                flit_cnt <= flit_cnt + 32'd1;
            if (accept && !(|in_dst_mask))
                drop_cnt <= drop_cnt + 32'd1;
            if (state == SEND && (|blocked))
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
